// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register file: 16-bit frames {wr, addr[6:0], data[7:0]}
// update the PWM / output-enable configuration registers.
module spi_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       txn_done
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam logic [6:0] MAX_A    = 7'(MAX_ADDR);
    localparam logic [2:0] SYNC_RST = 3'b001;  // {sclk, copi, ncs}

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        sclk_prev, ncs_prev;
    logic                        sclk_s, copi_s, ncs_s;
    logic                        sclk_rise, ncs_rise, ncs_fall;

    state_t          state;
    logic [4:0]      bit_cnt;
    logic [15:0]     shift_reg;
    logic [4:0][7:0] regs;
    logic            commit_ok;
    logic [6:0]      addr;

    assign sclk_s = sync_q[SYNC_STAGES-1][2];
    assign copi_s = sync_q[SYNC_STAGES-1][1];
    assign ncs_s  = sync_q[SYNC_STAGES-1][0];

    assign sclk_rise = sclk_s & ~sclk_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= {SYNC_STAGES{SYNC_RST}};
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], {sclk, copi, ncs}};
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
        end
    end

    // Only complete write frames to a decoded address ever touch the registers.
    assign addr      = shift_reg[14:8];
    assign commit_ok = (bit_cnt == 5'd16) && shift_reg[15] &&
                       (addr <= MAX_A) && (addr <= 7'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            regs      <= '0;
            txn_done  <= 1'b0;
        end else begin
            txn_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                SHIFT: begin
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise && bit_cnt != 5'd16) begin
                        shift_reg <= {shift_reg[14:0], copi_s};
                        bit_cnt   <= bit_cnt + 5'd1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (commit_ok) begin
                        regs[addr[2:0]] <= shift_reg[7:0];
                        txn_done        <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: bit-banged SPI frames with hand-computed
// register contents and txn_done pulse counts.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       txn_done;

    int         checks = 0;
    int         passed = 0;
    int         pulses = 0;
    logic [7:0] obs [5];
    logic [7:0] exp [5];

    always #50 clk = ~clk;

    spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .txn_done        (txn_done)
    );

    always_comb begin
        obs[0] = en_reg_out_7_0;
        obs[1] = en_reg_out_15_8;
        obs[2] = en_reg_pwm_7_0;
        obs[3] = en_reg_pwm_15_8;
        obs[4] = pwm_duty_cycle;
    end

    always @(negedge clk) if (txn_done === 1'b1) pulses++;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // sclk phases of 4 clk cycles each, comfortably above the synchroniser depth.
    task automatic spi_bits(input logic [31:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = word[i];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] word, input int nbits, input int gap);
        ncs = 1'b0;
        wait_clk(4);
        spi_bits(word, nbits);
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(gap);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(20);
        for (int i = 0; i < 5; i++) begin
            exp[i] = 8'h00;
            checks++;
            if (obs[i] !== exp[i]) $display("FAIL reset_reg%0d got %h want %h", i, obs[i], exp[i]);
            else passed++;
        end
        checks++;
        if (txn_done !== 1'b0) $display("FAIL reset_txn_done got %b want 0", txn_done);
        else passed++;
        checks++;
        if (pulses !== 0) $display("FAIL reset_pulses got %0d want 0", pulses);
        else passed++;
    endtask

    task automatic test_write;
        int p0;
        p0 = pulses;
        spi_frame(32'h8027, 16, 10);
        spi_frame(32'h81E7, 16, 10);
        spi_frame(32'h8296, 16, 10);
        spi_frame(32'h8385, 16, 10);
        spi_frame(32'h8411, 16, 10);
        exp[0] = 8'h27; exp[1] = 8'hE7; exp[2] = 8'h96; exp[3] = 8'h85; exp[4] = 8'h11;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp[i]) $display("FAIL write_reg%0d got %h want %h", i, obs[i], exp[i]);
            else passed++;
        end
        checks++;
        if (pulses - p0 !== 5) $display("FAIL write_pulses got %0d want 5", pulses - p0);
        else passed++;
    endtask

    task automatic test_drop;
        int p0;
        p0 = pulses;
        spi_frame(32'h85AA, 16, 10);
        spi_frame(32'h00FF, 16, 10);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp[i]) $display("FAIL drop_reg%0d got %h want %h", i, obs[i], exp[i]);
            else passed++;
        end
        checks++;
        if (pulses - p0 !== 0) $display("FAIL drop_pulses got %0d want 0", pulses - p0);
        else passed++;
    endtask

    task automatic test_short_long;
        int p0;
        p0 = pulses;
        spi_frame(32'h833, 12, 10);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp[i]) $display("FAIL short_reg%0d got %h want %h", i, obs[i], exp[i]);
            else passed++;
        end
        checks++;
        if (pulses - p0 !== 0) $display("FAIL short_pulses got %0d want 0", pulses - p0);
        else passed++;
        // 0x8455 followed by one extra '1' bit
        spi_frame(32'h108AB, 17, 10);
        exp[4] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp[i]) $display("FAIL long_reg%0d got %h want %h", i, obs[i], exp[i]);
            else passed++;
        end
        checks++;
        if (pulses - p0 !== 1) $display("FAIL long_pulses got %0d want 1", pulses - p0);
        else passed++;
    endtask

    task automatic test_idle_sclk_and_reset;
        int p0;
        p0 = pulses;
        copi = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            wait_clk(4);
        end
        wait_clk(10);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp[i]) $display("FAIL idle_sclk_reg%0d got %h want %h", i, obs[i], exp[i]);
            else passed++;
        end
        checks++;
        if (pulses - p0 !== 0) $display("FAIL idle_sclk_pulses got %0d want 0", pulses - p0);
        else passed++;
        // first 10 bits of 0x80FF, then reset mid-frame
        ncs = 1'b0;
        wait_clk(4);
        spi_bits(32'h203, 10);
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        ncs = 1'b1;
        wait_clk(10);
        for (int i = 0; i < 5; i++) begin
            exp[i] = 8'h00;
            checks++;
            if (obs[i] !== exp[i]) $display("FAIL midreset_reg%0d got %h want %h", i, obs[i], exp[i]);
            else passed++;
        end
        spi_frame(32'h80FF, 16, 10);
        exp[0] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp[i]) $display("FAIL postreset_reg%0d got %h want %h", i, obs[i], exp[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        int p0;
        p0 = pulses;
        spi_frame(32'h8411, 16, 2);
        spi_frame(32'h84C0, 16, 10);
        exp[4] = 8'hC0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp[i]) $display("FAIL b2b_reg%0d got %h want %h", i, obs[i], exp[i]);
            else passed++;
        end
        checks++;
        if (pulses - p0 !== 2) $display("FAIL b2b_pulses got %0d want 2", pulses - p0);
        else passed++;
    endtask

    // Raw ncs rise -> 2 sync flops -> rise detect -> commit: visible on the 4th edge.
    task automatic test_latency;
        ncs = 1'b0;
        wait_clk(4);
        spi_bits(32'h8277, 16);
        wait_clk(4);
        ncs = 1'b1;
        wait_clk(3);
        checks++;
        if (txn_done !== 1'b0) $display("FAIL lat_early_txn got %b want 0", txn_done);
        else passed++;
        checks++;
        if (en_reg_pwm_7_0 !== 8'h00) $display("FAIL lat_early_reg2 got %h want 00", en_reg_pwm_7_0);
        else passed++;
        wait_clk(1);
        checks++;
        if (txn_done !== 1'b1) $display("FAIL lat_pulse_txn got %b want 1", txn_done);
        else passed++;
        checks++;
        if (en_reg_pwm_7_0 !== 8'h77) $display("FAIL lat_reg2 got %h want 77", en_reg_pwm_7_0);
        else passed++;
        wait_clk(1);
        checks++;
        if (txn_done !== 1'b0) $display("FAIL lat_pulse_width got %b want 0", txn_done);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_write;
        test_drop;
        test_short_long;
        test_idle_sclk_and_reset;
        test_back_to_back;
        test_latency;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #(100 * 60000);
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

endmodule
